// File: rtl/fp_mult_share_arbiter.sv
// Round-robin share of one pipelined FP multiplier between two requesters; products return to their owner after 1+LATENCY cycles.
// Requesters hold req until gnt and cannot backpressure responses; clk_en is gated off when nothing is in flight.
module fp_mult_share_arbiter #(
  parameter int LATENCY = 5,
  parameter int WIDTH   = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  output logic             gnt0,
  output logic             rsp0_valid,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt1,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp_data,
  output logic [WIDTH-1:0] mult_dataa,
  output logic [WIDTH-1:0] mult_datab,
  output logic             mult_clk_en,
  output logic             mult_aclr,
  input  logic [WIDTH-1:0] mult_result,
  output logic             busy
);

  logic               favour1;
  logic [LATENCY:0]   vld;
  logic [LATENCY:0]   tag;
  logic               any_gnt;

  // Grants are suppressed while in reset so nothing is accepted that would be lost.
  assign gnt0    = reset_n & req0 & (~req1 | ~favour1);
  assign gnt1    = reset_n & req1 & (~req0 |  favour1);
  assign any_gnt = gnt0 | gnt1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      favour1    <= 1'b0;
      vld        <= '0;
      tag        <= '0;
      mult_dataa <= '0;
      mult_datab <= '0;
    end else begin
      if (any_gnt) begin
        favour1    <= gnt0;
        mult_dataa <= gnt1 ? a1 : a0;
        mult_datab <= gnt1 ? b1 : b0;
      end
      vld[0]         <= any_gnt;
      tag[0]         <= gnt1;
      vld[LATENCY:1] <= vld[LATENCY-1:0];
      tag[LATENCY:1] <= tag[LATENCY-1:0];
    end
  end

  // Stage LATENCY holds the product leaving the multiplier, so it needs no enable.
  assign mult_clk_en = |vld[LATENCY-1:0];
  assign busy        = |vld;
  assign mult_aclr   = ~reset_n;
  assign rsp_data    = mult_result;
  assign rsp0_valid  = vld[LATENCY] & ~tag[LATENCY];
  assign rsp1_valid  = vld[LATENCY] &  tag[LATENCY];

endmodule

// File: tb/tb_fp_mult_share_arbiter.sv
// Bench for fp_mult_share_arbiter: behavioural multiplier, transaction-level arbiter model checked every cycle, plus directed literal checks.
module tb_fp_mult_share_arbiter;
  localparam int LAT = 5;
  localparam int W   = 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          req0, req1;
  logic [W-1:0]  a0, b0, a1, b1;
  logic          gnt0, gnt1, rsp0_valid, rsp1_valid;
  logic [W-1:0]  rsp_data, mult_dataa, mult_datab, mult_result;
  logic          mult_clk_en, mult_aclr, busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp_mult_share_arbiter #(.LATENCY(LAT), .WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0(req0), .a0(a0), .b0(b0), .gnt0(gnt0), .rsp0_valid(rsp0_valid),
    .req1(req1), .a1(a1), .b1(b1), .gnt1(gnt1), .rsp1_valid(rsp1_valid),
    .rsp_data(rsp_data), .mult_dataa(mult_dataa), .mult_datab(mult_datab),
    .mult_clk_en(mult_clk_en), .mult_aclr(mult_aclr), .mult_result(mult_result),
    .busy(busy)
  );

  // Normal-number single-precision multiply; operands in this bench give exact products.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] m;
    logic [9:0]  e;
    logic        s;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'b0};
    m = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    e = {2'b0, a[30:23]} + {2'b0, b[30:23]} - 10'd127;
    if (m[47]) return {s, e[7:0] + 8'd1, m[46:24]};
    return {s, e[7:0], m[45:23]};
  endfunction

  // Multiplier model: LAT enabled edges from operand sample to result.
  logic [W-1:0] mstage [1:LAT];
  always @(posedge clk or posedge mult_aclr) begin
    if (mult_aclr) begin
      for (int k = 1; k <= LAT; k++) mstage[k] <= '0;
    end else if (mult_clk_en) begin
      mstage[1] <= fmul(mult_dataa, mult_datab);
      for (int k = 2; k <= LAT; k++) mstage[k] <= mstage[k-1];
    end
  end
  assign mult_result = mstage[LAT];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Transaction model: each grant is a record; outputs follow from its age.
  typedef struct {
    int          gcyc;
    bit          tag;
    logic [31:0] prod;
  } ent_t;
  ent_t        mq[$];
  int          cyc = 0;
  int          fav = 0;
  logic [31:0] exp_da = '0, exp_db = '0, edat;
  logic        eg0, eg1, er0, er1, een, ebusy;

  // Observation logs for the directed checks.
  int          g_tag[$], g_cyc[$], r_tag[$], r_cyc[$];
  logic [31:0] r_dat[$];
  int          en_cnt = 0;

  always @(negedge clk) begin
    cyc++;
    if (!reset_n) begin
      mq.delete();
      fav = 0; exp_da = '0; exp_db = '0;
      eg0 = 1'b0; eg1 = 1'b0;
    end else begin
      eg0 = req0 && (!req1 || fav == 0);
      eg1 = req1 && (!req0 || fav == 1);
    end
    er0 = 1'b0; er1 = 1'b0; een = 1'b0; ebusy = 1'b0; edat = '0;
    foreach (mq[i]) begin
      if (mq[i].gcyc + 1 + LAT == cyc) begin
        if (mq[i].tag) er1 = 1'b1; else er0 = 1'b1;
        edat = mq[i].prod;
      end
      if (cyc >= mq[i].gcyc + 1 && cyc <= mq[i].gcyc + LAT)     een   = 1'b1;
      if (cyc >= mq[i].gcyc + 1 && cyc <= mq[i].gcyc + 1 + LAT) ebusy = 1'b1;
    end
    check("gnt0", {31'b0, gnt0}, {31'b0, eg0});
    check("gnt1", {31'b0, gnt1}, {31'b0, eg1});
    check("rsp0_valid", {31'b0, rsp0_valid}, {31'b0, er0});
    check("rsp1_valid", {31'b0, rsp1_valid}, {31'b0, er1});
    check("mult_clk_en", {31'b0, mult_clk_en}, {31'b0, een});
    check("busy", {31'b0, busy}, {31'b0, ebusy});
    check("mult_aclr", {31'b0, mult_aclr}, {31'b0, ~reset_n});
    check("mult_dataa", mult_dataa, exp_da);
    check("mult_datab", mult_datab, exp_db);
    if (er0 || er1) check("rsp_data", rsp_data, edat);

    if (gnt0 || gnt1) begin g_tag.push_back(int'(gnt1)); g_cyc.push_back(cyc); end
    if (rsp0_valid || rsp1_valid) begin
      r_tag.push_back(int'(rsp1_valid)); r_cyc.push_back(cyc); r_dat.push_back(rsp_data);
    end
    if (mult_clk_en) en_cnt++;

    if (eg0 || eg1) begin
      mq.push_back('{cyc, eg1, fmul(eg1 ? a1 : a0, eg1 ? b1 : b0)});
      exp_da = eg1 ? a1 : a0;
      exp_db = eg1 ? b1 : b0;
      fav    = eg1 ? 0 : 1;
    end
    while (mq.size() > 0 && mq[0].gcyc + 1 + LAT <= cyc) void'(mq.pop_front());
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic clear_logs();
    g_tag.delete(); g_cyc.delete(); r_tag.delete(); r_cyc.delete(); r_dat.delete();
    en_cnt = 0;
  endtask

  task automatic single(input bit who, input logic [31:0] a, input logic [31:0] b);
    if (who) begin a1 = a; b1 = b; req1 = 1'b1; end
    else     begin a0 = a; b0 = b; req0 = 1'b1; end
    step(1);
    req0 = 1'b0; req1 = 1'b0;
  endtask

  initial begin
    reset_n = 1'b1; req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    #1 reset_n = 1'b0;

    // Reset with both requesting, then first grant must go to requester 0.
    req0 = 1'b1; req1 = 1'b1;
    a0 = 32'h3f800000; b0 = 32'h3f800000; a1 = 32'h40000000; b1 = 32'h40000000;
    step(3);
    check("t1_no_gnt_in_reset", g_tag.size(), 0);
    reset_n = 1'b1;
    step(1);
    req0 = 1'b0; req1 = 1'b0;
    step(10);
    check("t1_gnt_count", g_tag.size(), 1);
    if (g_tag.size() > 0) check("t1_first_gnt", g_tag[0], 0);

    // Single product from requester 0.
    clear_logs();
    single(1'b0, 32'h3f800000, 32'h40840000);
    step(10);
    check("t2_rsp_count", r_tag.size(), 1);
    if (r_tag.size() == 1 && g_cyc.size() == 1) begin
      check("t2_latency", r_cyc[0] - g_cyc[0], 6);
      check("t2_tag", r_tag[0], 0);
      check("t2_data", r_dat[0], 32'h40840000);
    end
    check("t2_busy_after", {31'b0, busy}, 32'd0);

    // Contention: favour is on requester 1 after two grants to 0.
    clear_logs();
    a0 = 32'h42ff8000; b0 = 32'h41de0000; a1 = 32'h45000000; b1 = 32'h45000000;
    req0 = 1'b1; req1 = 1'b1;
    step(8);
    req0 = 1'b0; req1 = 1'b0;
    step(10);
    check("t3_gnt_count", g_tag.size(), 8);
    check("t3_rsp_count", r_tag.size(), 8);
    if (g_tag.size() == 8 && r_tag.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        check("t3_gnt_order", g_tag[i], (i % 2 == 0) ? 1 : 0);
        check("t3_rsp_tag", r_tag[i], (i % 2 == 0) ? 1 : 0);
        check("t3_rsp_data", r_dat[i], (i % 2 == 0) ? 32'h4a800000 : 32'h455d9100);
        check("t3_rsp_cycle", r_cyc[i] - g_cyc[0], 6 + i);
      end
    end

    // Back-to-back from requester 0 with distinct operands.
    clear_logs();
    b0 = 32'h40840000; a0 = 32'h3f800000; req0 = 1'b1;
    step(1); a0 = 32'h40000000;
    step(1); a0 = 32'h40400000;
    step(1); a0 = 32'h40800000;
    step(1); req0 = 1'b0;
    step(10);
    check("t4_gnt_count", g_tag.size(), 4);
    check("t4_rsp_count", r_tag.size(), 4);
    if (r_tag.size() == 4) begin
      check("t4_data0", r_dat[0], 32'h40840000);
      check("t4_data1", r_dat[1], 32'h41040000);
      check("t4_data2", r_dat[2], 32'h41460000);
      check("t4_data3", r_dat[3], 32'h41840000);
      check("t4_contig", r_cyc[3] - r_cyc[0], 3);
    end
    check("t4_clk_en_cycles", en_cnt, 8);

    // Reset mid-flight discards three in-flight products.
    clear_logs();
    a0 = 32'h40000000; b0 = 32'h40000000; req0 = 1'b1;
    step(3);
    req0 = 1'b0;
    step(1);
    reset_n = 1'b0;
    step(1);
    reset_n = 1'b1;
    step(10);
    check("t5_gnt_count", g_tag.size(), 3);
    check("t5_no_rsp", r_tag.size(), 0);
    clear_logs();
    single(1'b1, 32'h40000000, 32'h40400000);
    step(10);
    check("t5_after_rsp_count", r_tag.size(), 1);
    if (r_tag.size() == 1 && g_cyc.size() == 1) begin
      check("t5_after_latency", r_cyc[0] - g_cyc[0], 6);
      check("t5_after_tag", r_tag[0], 1);
      check("t5_after_data", r_dat[0], 32'h40c00000);
    end

    // Idle gap between two products: clk_en only around each product.
    clear_logs();
    single(1'b0, 32'h40000000, 32'h40400000);
    step(10);
    single(1'b1, 32'h40400000, 32'h40800000);
    step(10);
    check("t6_clk_en_cycles", en_cnt, 10);
    check("t6_rsp_count", r_tag.size(), 2);
    if (r_tag.size() == 2) begin
      check("t6_tag0", r_tag[0], 0);
      check("t6_data0", r_dat[0], 32'h40c00000);
      check("t6_tag1", r_tag[1], 1);
      check("t6_data1", r_dat[1], 32'h41400000);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
